// File: rtl/mem_seq_ctrl_pkg.sv
// Shared definitions for the memory sequencer: FSM state encoding, host
// command opcodes and the default RAM geometry / halt instruction.
package mem_seq_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_HOLD
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD_IM = 2'b00,
    OP_LOAD_DM = 2'b01,
    OP_RUN     = 2'b10,
    OP_DUMP    = 2'b11
  } op_t;

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// Host-side stream bundle of the memory sequencer.
//   cmd_*  : command handshake (op, start word address, word count)
//   wr_*   : load-data stream into IMEM/DMEM
//   rd_*   : dump-data stream out of DMEM
// master = host, slave = sequencer.
interface mem_seq_ctrl_if
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  op_t               cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/mem_seq_ctrl_mem_port_mux.sv
// mem_port_mux: combinational owner selection for the IMEM and DMEM port
// sets. In S_RUN the processor drives both RAMs; otherwise the sequencer's
// own drive (idle, load write or dump read) passes through.
// Ports: state, ctrl_* (sequencer drive), cpu_* (processor drive),
//        im_* / dm_* (RAM controls, active-low, plus address/data).
module mem_port_mux
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  state_t            state,
  input  logic              ctrl_im_cen,
  input  logic              ctrl_im_wen,
  input  logic [ADDR_W-1:0] ctrl_im_addr,
  input  logic [DATA_W-1:0] ctrl_im_d,
  input  logic              ctrl_dm_cen,
  input  logic              ctrl_dm_wen,
  input  logic              ctrl_dm_oen,
  input  logic [ADDR_W-1:0] ctrl_dm_addr,
  input  logic [DATA_W-1:0] ctrl_dm_d,
  input  logic [DATA_W-1:0] cpu_pc,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_datain,
  input  logic              cpu_mw,
  input  logic              cpu_mr,
  output logic              im_cen,
  output logic              im_wen,
  output logic              im_oen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_d,
  output logic              dm_cen,
  output logic              dm_wen,
  output logic              dm_oen,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_d
);
  // Only the low word-address bits reach the 2K-word macros.
  logic unused_cpu_hi;
  assign unused_cpu_hi = ^{cpu_pc[DATA_W-1:ADDR_W], cpu_addr[DATA_W-1:ADDR_W]};

  always_comb begin
    im_cen  = ctrl_im_cen;
    im_wen  = ctrl_im_wen;
    im_oen  = 1'b1;
    im_addr = ctrl_im_addr;
    im_d    = ctrl_im_d;
    dm_cen  = ctrl_dm_cen;
    dm_wen  = ctrl_dm_wen;
    dm_oen  = ctrl_dm_oen;
    dm_addr = ctrl_dm_addr;
    dm_d    = ctrl_dm_d;
    if (state == S_RUN) begin
      im_cen  = 1'b0;
      im_wen  = 1'b1;
      im_oen  = 1'b0;
      im_addr = cpu_pc[ADDR_W-1:0];
      im_d    = '0;
      dm_cen  = 1'b0;
      dm_wen  = cpu_mw;
      dm_oen  = cpu_mr;
      dm_addr = cpu_addr[ADDR_W-1:0];
      dm_d    = cpu_datain;
    end
  end
endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: host-side sequencer for the processor's IMEM/DMEM macros.
// Bulk-loads either RAM from the host write stream, runs the processor
// until it fetches HALT_WORD, and streams DMEM ranges back to the host.
// Ports: clk, rst (sync, active-high); host (command/load/dump streams);
//        busy, halted, cycle_cnt status; cpu_reset_n and cpu_* processor
//        side; im_* / dm_* RAM port sets (controls active-low).
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  mem_seq_ctrl_if.slave     host,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       cycle_cnt,
  output logic              cpu_reset_n,
  input  logic [DATA_W-1:0] cpu_pc,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_datain,
  input  logic              cpu_mw,
  input  logic              cpu_mr,
  output logic              im_cen,
  output logic              im_wen,
  output logic              im_oen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_d,
  input  logic [DATA_W-1:0] im_q,
  output logic              dm_cen,
  output logic              dm_wen,
  output logic              dm_oen,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_d,
  input  logic [DATA_W-1:0] dm_q
);
  state_t            state_q, state_d;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              halted_q;
  logic [31:0]       cycle_q;

  logic accept, ld_we, ld_dm, rd_issue, rd_take, halt_hit, last_word;

  assign last_word = (cnt_q == (ADDR_W+1)'(1));
  assign halt_hit  = (state_q == S_RUN) && (im_q == HALT_WORD);

  always_comb begin
    state_d        = state_q;
    host.cmd_ready = 1'b0;
    host.wr_ready  = 1'b0;
    host.rd_valid  = 1'b0;
    accept         = 1'b0;
    ld_we          = 1'b0;
    rd_issue       = 1'b0;
    rd_take        = 1'b0;
    case (state_q)
      S_IDLE: begin
        host.cmd_ready = 1'b1;
        if (host.cmd_valid) begin
          accept = 1'b1;
          case (host.cmd_op)
            OP_LOAD_IM, OP_LOAD_DM: if (host.cmd_len != '0) state_d = S_LOAD;
            OP_RUN:                 state_d = S_RUN;
            default:                if (host.cmd_len != '0) state_d = S_RD_ISSUE;
          endcase
        end
      end
      S_LOAD: begin
        // Gating with rst keeps a word presented during reset out of the RAM.
        host.wr_ready = !rst;
        if (host.wr_valid && !rst) begin
          ld_we = 1'b1;
          if (last_word) state_d = S_IDLE;
        end
      end
      S_RUN:      if (halt_hit) state_d = S_IDLE;
      S_RD_ISSUE: begin
        rd_issue = 1'b1;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT:  state_d = S_RD_HOLD;
      S_RD_HOLD: begin
        host.rd_valid = 1'b1;
        if (host.rd_ready) begin
          rd_take = 1'b1;
          state_d = last_word ? S_IDLE : S_RD_ISSUE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_LOAD_IM;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      halted_q  <= 1'b0;
      cycle_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= host.cmd_op;
        addr_q <= host.cmd_addr;
        cnt_q  <= host.cmd_len;
        if (host.cmd_op == OP_RUN) begin
          halted_q <= 1'b0;
          cycle_q  <= '0;
        end
      end
      if (ld_we || rd_take) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - (ADDR_W+1)'(1);
      end
      if (state_q == S_RD_WAIT) rd_data_q <= dm_q;
      if (state_q == S_RUN && cycle_q != '1) cycle_q <= cycle_q + 32'd1;
      if (halt_hit) halted_q <= 1'b1;
    end
  end

  assign ld_dm = ld_we && (op_q == OP_LOAD_DM);

  logic              c_im_cen, c_im_wen, c_dm_cen, c_dm_wen, c_dm_oen;
  logic [ADDR_W-1:0] c_im_addr, c_dm_addr;
  logic [DATA_W-1:0] c_im_d, c_dm_d;

  always_comb begin
    c_im_cen  = !(ld_we && !ld_dm);
    c_im_wen  = c_im_cen;
    c_im_addr = c_im_cen ? '0 : addr_q;
    c_im_d    = c_im_cen ? '0 : host.wr_data;
    c_dm_cen  = !(ld_dm || rd_issue);
    c_dm_wen  = !ld_dm;
    c_dm_oen  = !rd_issue;
    c_dm_addr = c_dm_cen ? '0 : addr_q;
    c_dm_d    = ld_dm ? host.wr_data : '0;
  end

  mem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .state(state_q),
    .ctrl_im_cen(c_im_cen), .ctrl_im_wen(c_im_wen),
    .ctrl_im_addr(c_im_addr), .ctrl_im_d(c_im_d),
    .ctrl_dm_cen(c_dm_cen), .ctrl_dm_wen(c_dm_wen), .ctrl_dm_oen(c_dm_oen),
    .ctrl_dm_addr(c_dm_addr), .ctrl_dm_d(c_dm_d),
    .cpu_pc(cpu_pc), .cpu_addr(cpu_addr), .cpu_datain(cpu_datain),
    .cpu_mw(cpu_mw), .cpu_mr(cpu_mr),
    .im_cen(im_cen), .im_wen(im_wen), .im_oen(im_oen),
    .im_addr(im_addr), .im_d(im_d),
    .dm_cen(dm_cen), .dm_wen(dm_wen), .dm_oen(dm_oen),
    .dm_addr(dm_addr), .dm_d(dm_d)
  );

  assign busy         = (state_q != S_IDLE);
  assign cpu_reset_n  = (state_q == S_RUN);
  assign halted       = halted_q;
  assign cycle_cnt    = cycle_q;
  assign host.rd_data = rd_data_q;
endmodule
